// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit A + B + carry-in, DIGIT bits per clock; `SERIAL_ADDER_SUB_EN adds subtract mode.
// Latency: N+1 edges from accepted start to registered F/C_1/V (N = WIDTH/DIGIT); SA_DONE pulses on the completion edge.
// Backpressure: SA_START is only sampled while SA_BUSY is low; requests during RUN are dropped, not queued.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             SA_CLK,
   input  logic             SA_RST_N,
   input  logic             SA_START,
   input  logic [WIDTH-1:0] SA_A,
   input  logic [WIDTH-1:0] SA_B,
   input  logic             SA_C_0,
   input  logic             SA_SUB,
   output logic             SA_BUSY,
   output logic             SA_DONE,
   output logic [WIDTH-1:0] SA_F,
   output logic             SA_C_1,
   output logic             SA_V
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_eff   = SA_SUB ? ~SA_B : SA_B;
   assign cin_eff = SA_C_0 ^ SA_SUB;
`else
   logic unused_sub;
   assign unused_sub = SA_SUB;
   assign b_eff      = SA_B;
   assign cin_eff    = SA_C_0;
`endif

   logic [DIGIT:0]   dsum;
   logic             c_into_msb;
   logic [WIDTH-1:0] res_next;
   logic             last;

   assign dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
   // Carry into the top bit of this digit, recovered from its sum bit and operand bits.
   assign c_into_msb = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
   assign res_next   = (res_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
   assign last       = (cnt == CW'(N - 1));

   assign SA_BUSY = (state == S_RUN);

   always_ff @(posedge SA_CLK or negedge SA_RST_N) begin
      if (!SA_RST_N) begin
         state   <= S_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         SA_DONE <= 1'b0;
         SA_F    <= '0;
         SA_C_1  <= 1'b0;
         SA_V    <= 1'b0;
      end else begin
         SA_DONE <= 1'b0;
         if (state == S_IDLE) begin
            if (SA_START) begin
               a_sh   <= SA_A;
               b_sh   <= b_eff;
               carry  <= cin_eff;
               res_sh <= '0;
               cnt    <= '0;
               state  <= S_RUN;
            end
         end else begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= res_next;
            carry  <= dsum[DIGIT];
            cnt    <= cnt + CW'(1);
            if (last) begin
               SA_F    <= res_next;
               SA_C_1  <= dsum[DIGIT];
               SA_V    <= c_into_msb ^ dsum[DIGIT];
               SA_DONE <= 1'b1;
               state   <= S_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT=1 and DIGIT=4 instances at WIDTH=8, table vectors, corner sequences, random vs model.
module tb_serial_adder;

   logic clk;
   logic rst_n;

   logic       s1_start, s1_c0, s1_sub, s1_busy, s1_done, s1_c1, s1_v;
   logic [7:0] s1_a, s1_b, s1_f;
   logic       s4_start, s4_c0, s4_sub, s4_busy, s4_done, s4_c1, s4_v;
   logic [7:0] s4_a, s4_b, s4_f;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] last_f [2];
   logic       last_c1[2];
   logic       last_v [2];

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .SA_CLK(clk), .SA_RST_N(rst_n), .SA_START(s1_start),
      .SA_A(s1_a), .SA_B(s1_b), .SA_C_0(s1_c0), .SA_SUB(s1_sub),
      .SA_BUSY(s1_busy), .SA_DONE(s1_done), .SA_F(s1_f), .SA_C_1(s1_c1), .SA_V(s1_v)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .SA_CLK(clk), .SA_RST_N(rst_n), .SA_START(s4_start),
      .SA_A(s4_a), .SA_B(s4_b), .SA_C_0(s4_c0), .SA_SUB(s4_sub),
      .SA_BUSY(s4_busy), .SA_DONE(s4_done), .SA_F(s4_f), .SA_C_1(s4_c1), .SA_V(s4_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         sel;
      logic [7:0] a;
      logic [7:0] b;
      logic       c0;
      logic       sub;
      logic [7:0] f;
      logic       c1;
      logic       v;
      string      nm;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands, signed overflow from operand/result signs.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c0, input logic sub);
      logic       s;
      logic [7:0] bp;
      logic [8:0] sum;
      logic       v;
`ifdef SERIAL_ADDER_SUB_EN
      s = sub;
`else
      s = sub & 1'b0;
`endif
      bp  = s ? ~b : b;
      sum = {1'b0, a} + {1'b0, bp} + {8'b0, c0 ^ s};
      v   = (a[7] == bp[7]) && (sum[7] != a[7]);
      return {v, sum[8], sum[7:0]};
   endfunction

   function automatic logic d_done(input int sel);
      return (sel == 0) ? s1_done : s4_done;
   endfunction
   function automatic logic d_busy(input int sel);
      return (sel == 0) ? s1_busy : s4_busy;
   endfunction
   function automatic logic [9:0] d_res(input int sel);
      return (sel == 0) ? {s1_v, s1_c1, s1_f} : {s4_v, s4_c1, s4_f};
   endfunction

   task automatic clear_last();
      for (int i = 0; i < 2; i++) begin
         last_f[i] = 8'h00; last_c1[i] = 1'b0; last_v[i] = 1'b0;
      end
   endtask

   task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic c0,
                         input logic sub, input logic [7:0] ef, input logic ec1, input logic ev,
                         input string nm);
      int   n;
      int   busy_cnt;
      int   cyc;
      logic held;
      logic seen;
      logic [9:0] r;
      n = (sel == 0) ? 8 : 2;
      busy_cnt = 0; cyc = 0; held = 1'b1; seen = 1'b0;
      @(negedge clk);
      if (sel == 0) begin
         s1_start = 1'b1; s1_a = a; s1_b = b; s1_c0 = c0; s1_sub = sub;
      end else begin
         s4_start = 1'b1; s4_a = a; s4_b = b; s4_c0 = c0; s4_sub = sub;
      end
      @(negedge clk);
      s1_start = 1'b0; s4_start = 1'b0;
      // Operand pins change after acceptance; the result must not notice.
      s1_a = 8'($urandom); s1_b = 8'($urandom); s1_c0 = 1'($urandom); s1_sub = 1'($urandom);
      s4_a = 8'($urandom); s4_b = 8'($urandom); s4_c0 = 1'($urandom); s4_sub = 1'($urandom);
      while (cyc < 40) begin
         if (d_done(sel)) begin
            seen = 1'b1;
            break;
         end
         if (d_busy(sel)) busy_cnt++;
         if (d_res(sel) !== {last_v[sel], last_c1[sel], last_f[sel]}) held = 1'b0;
         @(negedge clk);
         cyc++;
      end
      r = d_res(sel);
      chk({nm, " done_seen"}, 32'(seen), 32'd1);
      chk({nm, " F"}, 32'(r[7:0]), 32'(ef));
      chk({nm, " C_1"}, 32'(r[8]), 32'(ec1));
      chk({nm, " V"}, 32'(r[9]), 32'(ev));
      chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(n));
      chk({nm, " outputs_held"}, 32'(held), 32'd1);
      last_f[sel] = ef; last_c1[sel] = ec1; last_v[sel] = ev;
      @(negedge clk);
      chk({nm, " done_one_cycle"}, 32'(d_done(sel)), 32'd0);
      chk({nm, " busy_after"}, 32'(d_busy(sel)), 32'd0);
   endtask

   initial begin
      int         k;
      int         cyc;
      logic       seen;
      int         sel;
      logic [7:0] ra, rb;
      logic       rc, rs;
      logic [9:0] m;

      rst_n = 1'b0;
      s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_c0 = 1'b0; s1_sub = 1'b0;
      s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_c0 = 1'b0; s4_sub = 1'b0;
      clear_last();

      tbl.push_back('{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff_plus_1"});
      tbl.push_back('{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "pos_overflow"});
      tbl.push_back('{0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, "carry_in_only"});
      tbl.push_back('{1, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "digit4_a5_5b"});
      tbl.push_back('{1, 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, "digit4_neg_overflow"});
`ifdef SERIAL_ADDER_SUB_EN
      tbl.push_back('{0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_5_7"});
      tbl.push_back('{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_overflow"});
      tbl.push_back('{1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "digit4_sub_5_7"});
`else
      tbl.push_back('{0, 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, "sub_ignored"});
      tbl.push_back('{1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, "digit4_sub_ignored"});
`endif

      #12;
      chk("reset BUSY", 32'(s1_busy), 32'd0);
      chk("reset DONE", 32'(s1_done), 32'd0);
      chk("reset F/C_1/V", 32'({s1_v, s1_c1, s1_f}), 32'd0);
      chk("reset d4 F/C_1/V/BUSY", 32'({s4_busy, s4_v, s4_c1, s4_f}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i])
         run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].c0, tbl[i].sub,
                tbl[i].f, tbl[i].c1, tbl[i].v, tbl[i].nm);

      // START held high across an operation, operands changed mid-RUN, re-accepted in the DONE cycle.
      @(negedge clk);
      s1_start = 1'b1; s1_a = 8'h10; s1_b = 8'h20; s1_c0 = 1'b0; s1_sub = 1'b0;
      @(negedge clk);
      repeat (3) @(negedge clk);
      s1_a = 8'h33; s1_b = 8'h44;
      seen = 1'b0; cyc = 0;
      while (cyc < 40) begin
         if (s1_done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      chk("held_start first done", 32'(seen), 32'd1);
      chk("held_start first F", 32'(s1_f), 32'h30);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!s1_done && k < 40);
      s1_start = 1'b0;
      chk("held_start done spacing", 32'(k), 32'd9);
      chk("held_start second F", 32'({s1_v, s1_c1, s1_f}), 32'h077);
      @(negedge clk);
      chk("held_start no third op", 32'({s1_busy, s1_done}), 32'd0);
      last_f[0] = 8'h77; last_c1[0] = 1'b0; last_v[0] = 1'b0;

      // Abort on the 4th RUN cycle after leaving nonzero results behind.
      run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "pre_abort");
      @(negedge clk);
      s1_start = 1'b1; s1_a = 8'hFF; s1_b = 8'hFF; s1_c0 = 1'b1; s1_sub = 1'b0;
      @(negedge clk);
      s1_start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort outputs", 32'({s1_busy, s1_done, s1_v, s1_c1, s1_f}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_last();
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (s1_done) seen = 1'b1;
      end
      chk("abort no done", 32'(seen), 32'd0);
      run_op(0, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "post_abort");

      for (int i = 0; i < 150; i++) begin
         sel = int'($urandom_range(0, 1));
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         m = model(ra, rb, rc, rs);
         run_op(sel, ra, rb, rc, rs, m[7:0], m[8], m[9], $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised successor to the single-bit full adder: adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, with an internal carry register. It is used where a wide combinational carry chain is too costly. A start/busy/done handshake lets a controller or FSM issue one operation at a time. Results, carry-out and signed overflow are held until the next operation completes.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥ 2.
- DIGIT, default 1: bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT cycles per operation.

Ports (clock and reset first):
- SA_CLK  in  1  clock, rising-edge active.
- SA_RST_N  in  1  asynchronous, active-low reset.
- SA_START  in  1  request; sampled only when SA_BUSY = 0.
- SA_A  in  WIDTH  operand A, captured at accepted start.
- SA_B  in  WIDTH  operand B, captured at accepted start.
- SA_C_0  in  1  carry-in, captured at accepted start.
- SA_SUB  in  1  subtract mode, captured at accepted start. Ignored unless the subtract feature is compiled in (see Configuration).
- SA_BUSY  out  1  high while an operation is in progress.
- SA_DONE  out  1  one-cycle pulse on completion.
- SA_F  out  WIDTH  result, registered.
- SA_C_1  out  1  carry-out, registered.
- SA_V  out  1  two's-complement overflow, registered.

## Operation
- The block has two states, IDLE and RUN.
- IDLE to RUN: SA_START = 1 at a clock edge.
  - Latch A, B and the effective carry.
  - Clear the digit counter.
  - Set SA_BUSY.
- In RUN, each edge performs the following:
  - Add the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shift the sum digit into the result shift register from the MSB side.
  - Shift A and B right by DIGIT bits.
  - Update the carry register.
  - Increment the counter.
- On the Nth RUN edge:
  - Load the final shift-register value into SA_F.
  - Set SA_C_1 to the carry out of bit WIDTH-1.
  - Set SA_V to the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1. The carry into the MSB is computed inside the last digit.
  - Pulse SA_DONE, clear SA_BUSY, return to IDLE.
- Arithmetic: {SA_C_1, SA_F} = A + B' + cin, modulo 2^(WIDTH+1).
  - For add: B' = B and cin = SA_C_0.
- SA_F, SA_C_1 and SA_V keep their previous values throughout RUN. They change only at the completion edge.
- SA_START while SA_BUSY = 1 is ignored. It is not queued, and operand changes during RUN have no effect.
- SA_START asserted during the SA_DONE cycle is accepted, because SA_BUSY is already 0 in that cycle.
- Reset asserted mid-operation aborts the operation immediately. No SA_DONE pulse is produced and outputs go to their reset values.

## Timing
- Reset values:
  - SA_BUSY = 0, SA_DONE = 0, SA_F = 0, SA_C_1 = 0, SA_V = 0.
  - State IDLE; all internal registers 0.
- Start accepted at edge 0: SA_BUSY is high after edge 0. Results, SA_DONE = 1 and SA_BUSY = 0 are all valid after edge N.
- Latency is N+1 edges from start sample to result visible. Maximum throughput is one operation per N+1 cycles.
- SA_DONE is high for exactly one cycle per completed operation.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - SA_SUB is captured at start.
  - When SA_SUB = 1: B' = ~B and cin = SA_C_0 XOR 1, so the block computes A − B − SA_C_0.
  - SA_C_1 = 1 means no borrow. SA_V is the signed-subtraction overflow.
- SERIAL_ADDER_SUB_EN undefined: SA_SUB is unconnected internally and treated as 0. The block is add-only and has no inverter logic on B.

## Test plan
- WIDTH=8, DIGIT=1; start with A=0xFF, B=0x01, C_0=0 → after 8 RUN edges: F=0x00, C_1=1, V=0, single DONE pulse; BUSY high exactly 8 cycles.
- A=0x7F, B=0x01, C_0=0 → F=0x80, C_1=0, V=1. Also A=0x00, B=0x00, C_0=1 → F=0x01, C_1=0, V=0.
- Hold START high across an operation, changing A and B mid-RUN:
  - The first result is unaffected by the operand changes.
  - A second operation is accepted in the DONE cycle, and the second DONE arrives 9 cycles after the first.
- Deassert SA_RST_N on the 4th RUN cycle → all outputs 0 immediately, no DONE pulse; the next start completes normally.
- WIDTH=8, DIGIT=4; A=0xA5, B=0x5B, C_0=0 → DONE after 2 RUN edges, F=0x00, C_1=1, V=0.
- With SERIAL_ADDER_SUB_EN: SUB=1, A=0x05, B=0x07, C_0=0 → F=0xFE, C_1=0, V=0. Also A=0x80, B=0x01, C_0=0 → F=0x7F, C_1=1, V=1.
